// File: rtl/picomem_pkg.sv
// Shared PicoMem bus constants and mux FSM encoding.
package picomem_pkg;

  localparam int unsigned PICOMEM_MAX_SLAVES = 8;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] PICOMEM_ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StErr
  } mux_state_e;

endpackage

// File: rtl/picomem_addr_decode.sv
// Combinational base/mask address decode; lowest matching index wins.
module picomem_addr_decode
  import picomem_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES = 4,
  parameter logic [ADDR_W*NUM_SLAVES-1:0] ADDR_BASE  = {NUM_SLAVES{32'h0}},
  parameter logic [ADDR_W*NUM_SLAVES-1:0] ADDR_MASK  = {NUM_SLAVES{32'hC000_0000}}
) (
  input  logic [ADDR_W-1:0]     addr_i,
  output logic [NUM_SLAVES-1:0] sel_o,
  output logic                  hit_o
);

  always_comb begin
    sel_o = '0;
    hit_o = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!hit_o && ((addr_i & ADDR_MASK[ADDR_W*i +: ADDR_W]) ==
                     (ADDR_BASE[ADDR_W*i +: ADDR_W] & ADDR_MASK[ADDR_W*i +: ADDR_W]))) begin
        sel_o[i] = 1'b1;
        hit_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/picomem_mux_1_n.sv
// 1-master to N-slave PicoMem interconnect with unmapped/timeout error termination.
// Optional PICOMEM_MUX_ERR_CAPTURE_EN adds err_addr/err_count capture outputs.
module picomem_mux_1_n
  import picomem_pkg::*;
#(
  parameter int unsigned                  NUM_SLAVES     = 4,
  parameter logic [ADDR_W*NUM_SLAVES-1:0] ADDR_BASE      = {NUM_SLAVES{32'h0}},
  parameter logic [ADDR_W*NUM_SLAVES-1:0] ADDR_MASK      = {NUM_SLAVES{32'hC000_0000}},
  parameter int unsigned                  TIMEOUT_CYCLES = 255,
  parameter logic [DATA_W-1:0]            ERR_RDATA      = PICOMEM_ERR_RDATA
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         picom_valid,
  output logic                         picom_ready,
  input  logic [ADDR_W-1:0]            picom_addr,
  input  logic [DATA_W-1:0]            picom_wdata,
  input  logic [STRB_W-1:0]            picom_wstrb,
  output logic [DATA_W-1:0]            picom_rdata,
  output logic [NUM_SLAVES-1:0]        picos_valid,
  input  logic [NUM_SLAVES-1:0]        picos_ready,
  output logic [ADDR_W-1:0]            picos_addr,
  output logic [DATA_W-1:0]            picos_wdata,
  output logic [STRB_W-1:0]            picos_wstrb,
  input  logic [DATA_W*NUM_SLAVES-1:0] picos_rdata,
  output logic                         bus_err
`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [7:0]                   err_count
`endif
);

  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  mux_state_e              state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       wdata_q, wdata_d;
  logic [STRB_W-1:0]       wstrb_q, wstrb_d;
  logic [15:0]             cnt_q, cnt_d;
  logic                    err_arm_q, err_arm_d;

  logic [NUM_SLAVES-1:0]   dec_sel;
  logic                    dec_hit;
  logic                    sel_ready;
  logic                    timeout;
  logic [DATA_W-1:0]       sel_rdata;

  picomem_addr_decode #(
    .NUM_SLAVES(NUM_SLAVES),
    .ADDR_BASE (ADDR_BASE),
    .ADDR_MASK (ADDR_MASK)
  ) u_decode (
    .addr_i(picom_addr),
    .sel_o (dec_sel),
    .hit_o (dec_hit)
  );

  assign sel_ready   = |(picos_ready & sel_q);
  assign timeout     = (cnt_q == TimeoutLast);
  assign picos_addr  = addr_q;
  assign picos_wdata = wdata_q;
  assign picos_wstrb = wstrb_q;

  // sel_q is one-hot (or zero), so an AND-OR mux is sufficient.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      sel_rdata = sel_rdata | (picos_rdata[DATA_W*i +: DATA_W] & {DATA_W{sel_q[i]}});
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    cnt_d       = cnt_q;
    err_arm_d   = 1'b0;
    picos_valid = '0;
    picom_ready = 1'b0;
    picom_rdata = '0;
    bus_err     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (picom_valid) begin
          addr_d  = picom_addr;
          wdata_d = picom_wdata;
          wstrb_d = picom_wstrb;
          sel_d   = dec_sel;
          cnt_d   = '0;
          if (dec_hit) begin
            state_d = StActive;
          end else begin
            state_d   = StErr;
            err_arm_d = 1'b1;
          end
        end
      end
      StActive: begin
        if (sel_ready) begin
          picos_valid = sel_q;
          picom_ready = 1'b1;
          picom_rdata = sel_rdata;
          state_d     = StIdle;
        end else if (timeout) begin
          picom_ready = 1'b1;
          picom_rdata = ERR_RDATA;
          bus_err     = 1'b1;
          state_d     = StIdle;
        end else begin
          picos_valid = sel_q;
          cnt_d       = cnt_q + 16'd1;
        end
      end
      StErr: begin
        // One quiet cycle first so the error response lands 2 cycles after valid.
        if (!err_arm_q) begin
          picom_ready = 1'b1;
          picom_rdata = ERR_RDATA;
          bus_err     = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      sel_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      cnt_q     <= '0;
      err_arm_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      cnt_q     <= cnt_d;
      err_arm_q <= err_arm_d;
    end
  end

`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic [7:0]        err_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      err_addr_q  <= '0;
      err_count_q <= '0;
    end else if (bus_err) begin
      err_addr_q <= addr_q;
      if (err_count_q != 8'hFF) begin
        err_count_q <= err_count_q + 8'd1;
      end
    end
  end

  assign err_addr  = err_addr_q;
  assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_picomem_mux_1_n.sv
// Randomized self-checking bench for picomem_mux_1_n: three instances
// (4-slave full map, 2-slave with a hole, 2-slave fully overlapping).
module tb_picomem_mux_1_n;

  localparam int ND = 3;
  localparam int T  = 16;
  localparam logic [31:0] ERRV = 32'hDEAD_BEEF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        m_valid[ND];
  logic [31:0] m_addr[ND];
  logic [31:0] m_wdata[ND];
  logic [3:0]  m_wstrb[ND];
  logic        m_ready[ND];
  logic [31:0] m_rdata[ND];
  logic        berr[ND];
  logic [3:0]  s_valid[ND];
  logic [3:0]  s_ready[ND];
  logic [31:0] s_addr[ND];
  logic [31:0] s_wdata[ND];
  logic [3:0]  s_wstrb[ND];
  logic [127:0] s_rdata[ND];
  logic [1:0]  s_valid_b;
  logic [1:0]  s_valid_c;

  assign s_valid[1] = {2'b00, s_valid_b};
  assign s_valid[2] = {2'b00, s_valid_c};

`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
  logic [31:0] e_addr[ND];
  logic [7:0]  e_cnt[ND];
`endif

  // Reference configuration mirrored from the instance parameters below.
  logic [31:0] cfg_base[ND][4];
  logic [31:0] cfg_mask[ND][4];
  int          nslv[ND];
  int          exp_err_cnt[ND];
  logic [31:0] exp_err_addr[ND];

  int n_total = 0;
  int n_bad   = 0;

  picomem_mux_1_n #(
    .NUM_SLAVES    (4),
    .ADDR_BASE     ({32'hC000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000}),
    .ADDR_MASK     ({4{32'hC000_0000}}),
    .TIMEOUT_CYCLES(T)
  ) u_dut_a (
    .clk(clk), .reset(reset), .picom_valid(m_valid[0]), .picom_ready(m_ready[0]),
    .picom_addr(m_addr[0]), .picom_wdata(m_wdata[0]), .picom_wstrb(m_wstrb[0]),
    .picom_rdata(m_rdata[0]), .picos_valid(s_valid[0]), .picos_ready(s_ready[0]),
    .picos_addr(s_addr[0]), .picos_wdata(s_wdata[0]), .picos_wstrb(s_wstrb[0]),
    .picos_rdata(s_rdata[0]), .bus_err(berr[0])
`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
    , .err_addr(e_addr[0]), .err_count(e_cnt[0])
`endif
  );

  picomem_mux_1_n #(
    .NUM_SLAVES    (2),
    .ADDR_BASE     ({32'h4000_0000, 32'h0000_0000}),
    .ADDR_MASK     ({2{32'hC000_0000}}),
    .TIMEOUT_CYCLES(T)
  ) u_dut_b (
    .clk(clk), .reset(reset), .picom_valid(m_valid[1]), .picom_ready(m_ready[1]),
    .picom_addr(m_addr[1]), .picom_wdata(m_wdata[1]), .picom_wstrb(m_wstrb[1]),
    .picom_rdata(m_rdata[1]), .picos_valid(s_valid_b), .picos_ready(s_ready[1][1:0]),
    .picos_addr(s_addr[1]), .picos_wdata(s_wdata[1]), .picos_wstrb(s_wstrb[1]),
    .picos_rdata(s_rdata[1][63:0]), .bus_err(berr[1])
`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
    , .err_addr(e_addr[1]), .err_count(e_cnt[1])
`endif
  );

  picomem_mux_1_n #(
    .NUM_SLAVES    (2),
    .ADDR_BASE     ({32'h0, 32'h0}),
    .ADDR_MASK     ({32'h0, 32'h0}),
    .TIMEOUT_CYCLES(T)
  ) u_dut_c (
    .clk(clk), .reset(reset), .picom_valid(m_valid[2]), .picom_ready(m_ready[2]),
    .picom_addr(m_addr[2]), .picom_wdata(m_wdata[2]), .picom_wstrb(m_wstrb[2]),
    .picom_rdata(m_rdata[2]), .picos_valid(s_valid_c), .picos_ready(s_ready[2][1:0]),
    .picos_addr(s_addr[2]), .picos_wdata(s_wdata[2]), .picos_wstrb(s_wstrb[2]),
    .picos_rdata(s_rdata[2][63:0]), .bus_err(berr[2])
`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
    , .err_addr(e_addr[2]), .err_count(e_cnt[2])
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_slave(input int d, input logic [31:0] a);
    for (int i = 0; i < nslv[d]; i++) begin
      if ((a & cfg_mask[d][i]) == (cfg_base[d][i] & cfg_mask[d][i])) return i;
    end
    return -1;
  endfunction

  task automatic check_idle_outputs(input int d, input string tag);
    check_eq({tag, " ready"}, 32'(m_ready[d]), 32'd0);
    check_eq({tag, " rdata"}, m_rdata[d], 32'd0);
    check_eq({tag, " bus_err"}, 32'(berr[d]), 32'd0);
    check_eq({tag, " picos_valid"}, 32'(s_valid[d]), 32'd0);
  endtask

  task automatic check_err_capture(input int d);
`ifdef PICOMEM_MUX_ERR_CAPTURE_EN
    check_eq($sformatf("d%0d err_count", d), 32'(e_cnt[d]), 32'(exp_err_cnt[d]));
    check_eq($sformatf("d%0d err_addr", d), e_addr[d], exp_err_addr[d]);
`endif
  endtask

  // One full master transaction; delay = cycles from slave valid to slave ready.
  task automatic run_txn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int delay, input logic [31:0] rdv);
    int   sl;
    int   done_c;
    bit   is_err;
    logic exp_ready;
    logic [31:0] exp_rd;
    logic [3:0]  exp_valid;
    string tag;
    sl = exp_slave(d, addr);
    if (sl < 0) begin
      done_c = 2;
      is_err = 1'b1;
    end else if (delay + 1 <= T) begin
      done_c = delay + 1;
      is_err = 1'b0;
    end else begin
      done_c = T;
      is_err = 1'b1;
    end
    #2;
    m_valid[d] = 1'b1;
    m_addr[d]  = addr;
    m_wdata[d] = wdata;
    m_wstrb[d] = wstrb;
    @(posedge clk);
    for (int c = 1; c <= done_c + 1; c++) begin
      #1;
      s_rdata[d] = {$urandom, $urandom, $urandom, $urandom};
      if (sl >= 0) s_rdata[d][32*sl +: 32] = rdv;
      s_ready[d] = 4'($urandom);
      if (sl >= 0) s_ready[d][sl] = (c == delay + 1);
      #1;
      tag       = $sformatf("d%0d a=%h c%0d", d, addr, c);
      exp_ready = (c == done_c);
      exp_rd    = !exp_ready ? 32'd0 : (is_err ? ERRV : rdv);
      exp_valid = (sl >= 0 && (c < done_c || (c == done_c && !is_err))) ? (4'd1 << sl) : 4'd0;
      check_eq({tag, " ready"}, 32'(m_ready[d]), 32'(exp_ready));
      check_eq({tag, " rdata"}, m_rdata[d], exp_rd);
      check_eq({tag, " bus_err"}, 32'(berr[d]), 32'(exp_ready && is_err));
      check_eq({tag, " picos_valid"}, 32'(s_valid[d]), 32'(exp_valid));
      if (c == 1) begin
        check_eq({tag, " picos_addr"}, s_addr[d], addr);
        check_eq({tag, " picos_wdata"}, s_wdata[d], wdata);
        check_eq({tag, " picos_wstrb"}, 32'(s_wstrb[d]), 32'(wstrb));
      end
      if (exp_ready) begin
        m_valid[d] = 1'b0;
        m_addr[d]  = $urandom;
        if (is_err) begin
          if (exp_err_cnt[d] < 255) exp_err_cnt[d]++;
          exp_err_addr[d] = addr;
        end
      end
      @(posedge clk);
    end
    s_ready[d] = 4'd0;
  endtask

  task automatic clear_err_model();
    for (int d = 0; d < ND; d++) begin
      exp_err_cnt[d]  = 0;
      exp_err_addr[d] = 32'd0;
    end
  endtask

  initial begin
    int d;
    int dl;
    logic [31:0] a;
    int delays[8] = '{0, 1, 2, 3, 14, 15, 16, 40};

    cfg_base[0] = '{32'h0000_0000, 32'h4000_0000, 32'h8000_0000, 32'hC000_0000};
    cfg_mask[0] = '{32'hC000_0000, 32'hC000_0000, 32'hC000_0000, 32'hC000_0000};
    cfg_base[1] = '{32'h0000_0000, 32'h4000_0000, 32'h0, 32'h0};
    cfg_mask[1] = '{32'hC000_0000, 32'hC000_0000, 32'h0, 32'h0};
    cfg_base[2] = '{32'h0, 32'h0, 32'h0, 32'h0};
    cfg_mask[2] = '{32'h0, 32'h0, 32'h0, 32'h0};
    nslv = '{4, 2, 2};
    clear_err_model();

    reset = 1'b1;
    for (int i = 0; i < ND; i++) begin
      m_valid[i] = 1'b0;
      m_addr[i]  = 32'd0;
      m_wdata[i] = 32'd0;
      m_wstrb[i] = 4'd0;
      s_ready[i] = 4'd0;
      s_rdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      check_idle_outputs(i, $sformatf("reset d%0d", i));
      check_eq($sformatf("reset d%0d picos_addr", i), s_addr[i], 32'd0);
      check_err_capture(i);
    end
    reset = 1'b0;
    @(posedge clk);

    // Directed cases.
    run_txn(0, 32'h4000_0010, 32'h0, 4'h0, 2, 32'h1234_5678);
    run_txn(0, 32'h8000_0004, 32'hA5A5_0001, 4'hF, 0, 32'h0BAD_F00D);
    run_txn(1, 32'hC000_0000, 32'h0, 4'h0, 0, 32'h0);
    run_txn(0, 32'hC000_0100, 32'h0, 4'h0, 1000, 32'h7777_0001);
    run_txn(0, 32'hC000_0100, 32'h0, 4'h0, 15, 32'h7777_0002);

    // Reset while a transaction is active, then a late slave completion.
    #2;
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'hC000_0100;
    m_wdata[0] = 32'h1111_2222;
    m_wstrb[0] = 4'h3;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    m_valid[0] = 1'b0;
    reset      = 1'b1;
    @(posedge clk);
    #2;
    reset      = 1'b0;
    clear_err_model();
    s_ready[0] = 4'b1000;
    s_rdata[0] = {4{32'h5555_AAAA}};
    #1;
    check_idle_outputs(0, "post-reset");
    check_eq("post-reset picos_addr", s_addr[0], 32'd0);
    check_eq("post-reset picos_wdata", s_wdata[0], 32'd0);
    check_eq("post-reset picos_wstrb", 32'(s_wstrb[0]), 32'd0);
    @(posedge clk);
    #1;
    check_idle_outputs(0, "post-reset+1");
    s_ready[0] = 4'd0;
    @(posedge clk);
    run_txn(0, 32'h0000_0000, 32'h0, 4'h0, 1, 32'hCAFE_0000);

    // Overlapping map: slave0 always wins.
    for (int i = 0; i < 4; i++) begin
      run_txn(2, $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 3)), $urandom);
    end

    // Two unmapped errors on the 2-slave map.
    run_txn(1, 32'h8000_0000, 32'h0, 4'h0, 0, 32'h0);
    run_txn(1, 32'hC000_1234, 32'hFFFF_0000, 4'hF, 0, 32'h0);
    check_err_capture(1);

    // Randomized traffic across all three instances.
    for (int i = 0; i < 60; i++) begin
      d  = int'($urandom_range(0, ND - 1));
      a  = $urandom;
      dl = delays[$urandom_range(0, 7)];
      run_txn(d, a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom), dl, $urandom);
    end
    for (int i = 0; i < ND; i++) check_err_capture(i);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/picomem_mux_1_n.md
Name: picomem_mux_1_n

Overview:
- Parametrised 1-master to N-slave PicoMem interconnect; successor to the fixed 1:4 mux used at the SoC top and in the peripheral sub-bus.
- Registers address decode, holds slave select for the whole transaction, and terminates unmapped or hung accesses with an error response, so the core can never deadlock on the bus.
- Sits between picorv32 (or an upstream mux) and its slaves; cascadable.

Parameters:
- NUM_SLAVES, 4, number of slave ports (1..8).
- ADDR_BASE, {NUM_SLAVES{32'h0}}, flattened 32-bit base per slave; slave i uses bits [32*i+31:32*i].
- ADDR_MASK, {NUM_SLAVES{32'hC000_0000}}, flattened 32-bit compare mask per slave.
- TIMEOUT_CYCLES, 255, ACTIVE cycles without slave ready before a forced error (1..65535).
- ERR_RDATA, 32'hDEAD_BEEF, read data returned on error termination.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- picom_valid  in  1  master request
- picom_ready  out  1  master completion, one-cycle pulse
- picom_addr  in  32  master address
- picom_wdata  in  32  master write data
- picom_wstrb  in  4  byte strobes; 0 = read
- picom_rdata  out  32  read data, valid while picom_ready=1
- picos_valid  out  NUM_SLAVES  one-hot slave request
- picos_ready  in  NUM_SLAVES  per-slave completion
- picos_addr  out  32  registered address, broadcast to all slaves
- picos_wdata  out  32  registered write data, broadcast
- picos_wstrb  out  4  registered strobes, broadcast
- picos_rdata  in  32*NUM_SLAVES  flattened per-slave read data
- bus_err  out  1  one-cycle pulse on any error termination

Behaviour:
- Match rule: slave i matches when (picom_addr & MASK_i) == (BASE_i & MASK_i). On overlap the lowest index wins.
- FSM states: IDLE, ACTIVE, ERR.
- IDLE, picom_valid=1:
  - Latch addr, wdata, wstrb and one-hot sel_q.
  - If a slave matches, go to ACTIVE; otherwise go to ERR.
  - picom_ready=0 in IDLE.
- ACTIVE:
  - picos_valid = sel_q; picom_ready = |(picos_ready & sel_q); picom_rdata = selected slave's rdata (combinational mux).
  - Ready from non-selected slaves is ignored.
  - On selected ready, go to IDLE; picos_valid drops the next cycle.
- Timeout: counter clears on entry to ACTIVE and increments each ACTIVE cycle without ready. When it reaches TIMEOUT_CYCLES:
  - picom_ready=1, picom_rdata=ERR_RDATA, bus_err=1, picos_valid forced 0 that cycle, go to IDLE.
  - A slave ready in the same cycle takes priority: normal completion, no error.
- ERR: one cycle with picom_ready=1, picom_rdata=ERR_RDATA, bus_err=1, picos_valid=0; then IDLE. Writes to unmapped space are dropped.
- Latency: slave sees valid 1 cycle after the master. Best case (slave ready the same cycle) gives picom_ready 1 cycle after picom_valid. Unmapped access gives ready 2 cycles after valid.
- Master must drop picom_valid the cycle after picom_ready (PicoMem rule). IDLE never accepts in a cycle where picom_ready=1.
- picom_rdata = 0 whenever picom_ready=0.
- Reset (any state):
  - state=IDLE; picos_valid=0, picom_ready=0, bus_err=0, counter=0, sel_q=0; picos_addr/wdata/wstrb=0.
  - An in-flight slave completion after reset is ignored.
- NUM_SLAVES=1 is legal; the decode then degenerates to match / no-match.

Optional Feature:
- Macro: PICOMEM_MUX_ERR_CAPTURE_EN.
- Defined: adds outputs err_addr[31:0] and err_count[7:0].
  - err_addr latches the address of the most recent error termination.
  - err_count increments per error and saturates at 255.
  - Both reset to 0.
- Undefined: neither port nor register exists; all other behaviour is identical.

Decomposition:
- Package picomem_pkg holds: FSM state encoding, PICOMEM_MAX_SLAVES=8, PICOMEM_ERR_RDATA default, and PicoMem width constants (ADDR_W=32, DATA_W=32, STRB_W=4).
- One sub-module, picomem_addr_decode: purely combinational base/mask match plus lowest-index priority, producing one-hot select and a hit flag.
- FSM, registers and timeout counter stay in the top module.

Test Plan:
- Config for all tests: NUM_SLAVES=4; bases 0x0000_0000/0x4000_0000/0x8000_0000/0xC000_0000; mask 0xC000_0000 each; TIMEOUT_CYCLES=16.
- Read 0x4000_0010; slave1 asserts ready 2 cycles after its valid with rdata 0x1234_5678 -> picos_valid=4'b0010 only, picom_ready one pulse with 0x1234_5678, picos_addr=0x4000_0010, bus_err=0.
- Write 0x8000_0004, wdata 0xA5A5_0001, wstrb 4'hF, slave2 ready the same cycle -> picom_ready 1 cycle after picom_valid, slave2 sees wdata/wstrb, other picos_valid stay 0.
- NUM_SLAVES=2 (bases 0x0/0x4000_0000), read 0xC000_0000 -> picos_valid stays 0, picom_ready 2 cycles after valid with 0xDEAD_BEEF, bus_err one pulse.
- Slave3 never ready on read 0xC000_0100 -> picom_ready and bus_err at ACTIVE cycle 16 with 0xDEAD_BEEF, picos_valid drops that cycle. Repeat with slave ready exactly at cycle 16 -> slave data returned, bus_err=0.
- Assert reset during ACTIVE, then slave ready after reset -> all outputs 0, state IDLE, no picom_ready. The next read to 0x0000_0000 completes normally.
- Overlap: ADDR_BASE1 = ADDR_BASE0 = 0, masks 0 -> slave0 selected for every address. With PICOMEM_MUX_ERR_CAPTURE_EN, two unmapped errors -> err_count=2, err_addr = second address.
